// File: rtl/output_driver_pkg.sv
// -----------------------------------------------------------------------------
// output_driver_pkg
// Shared definitions for the output pulse driver:
//   NUM_CH       - number of independent output channels
//   chan_state_e - per-channel FSM state (IDLE, HIGH, GAP)
//   cnt_width()  - width of the per-channel high/gap down-counter
// -----------------------------------------------------------------------------
package output_driver_pkg;

  localparam int NUM_CH = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } chan_state_e;

  // The counter is loaded with LEN-1 and counts down to 0, so $clog2 of the
  // larger length is enough.  It is clamped to 1 bit so a 1/1 configuration
  // still gets a legal vector.
  function automatic int cnt_width(input int pulse_len, input int gap_len);
    int m;
    m = (pulse_len > gap_len) ? pulse_len : gap_len;
    return ($clog2(m) < 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/output_driver_if.sv
// -----------------------------------------------------------------------------
// output_driver_if
// Groups the event strobes and pulse/status outputs of output_driver.
//   event_1..3  : one-cycle event strobes from the core logic
//   output_1..3 : registered pulse outputs
//   busy        : per-channel activity (bit k-1 = channel k)
//   overflow    : per-channel sticky "event lost" flag
// Modports: master = core-logic side, slave = the driver itself.
// -----------------------------------------------------------------------------
interface output_driver_if
  import output_driver_pkg::*;
  ;
  logic              event_1;
  logic              event_2;
  logic              event_3;
  logic              output_1;
  logic              output_2;
  logic              output_3;
  logic [NUM_CH-1:0] busy;
  logic [NUM_CH-1:0] overflow;

  modport master (
    output event_1, event_2, event_3,
    input  output_1, output_2, output_3, busy, overflow
  );

  modport slave (
    input  event_1, event_2, event_3,
    output output_1, output_2, output_3, busy, overflow
  );
endinterface

// File: rtl/output_driver_chan.sv
// -----------------------------------------------------------------------------
// output_driver_chan
// One pulse channel: IDLE/HIGH/GAP FSM, high/gap down-counter, registered
// pulse output, sticky overflow flag and (optionally) a pending-event counter.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   event_i     : one-cycle event strobe (high N cycles = N events)
//   pulse_o     : registered pulse output, PULSE_LEN cycles high
//   busy_o      : channel in HIGH/GAP or has pending events
//   overflow_o  : sticky, set when an event had to be discarded
// Build option: OUTPUT_DRIVER_QUEUE_EN enables the pending counter and replay.
// Without it, events arriving while busy (other than on the last GAP cycle)
// are discarded and flagged in overflow_o.
// -----------------------------------------------------------------------------
module output_driver_chan
  import output_driver_pkg::*;
#(
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN   = 2,
  parameter int PEND_W    = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic event_i,
  output logic pulse_o,
  output logic busy_o,
  output logic overflow_o
);

  localparam int            CW         = cnt_width(PULSE_LEN, GAP_LEN);
  localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_LEN - 1);
  localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_LEN - 1);

  chan_state_e   state_q;
  logic [CW-1:0] cnt_q;
  logic          out_q;
  logic          ovf_q;
  logic          ovf_d;

  logic cnt_zero;
  logic queue_win;   // an event now cannot start a pulse and must wait
  logic start_slot;  // a pulse may start on this edge
  logic pend_nz;
  logic start;

  assign cnt_zero   = (cnt_q == '0);
  assign queue_win  = (state_q == HIGH) || ((state_q == GAP) && !cnt_zero);
  assign start_slot = (state_q == IDLE) || ((state_q == GAP) && cnt_zero);
  assign start      = start_slot && (event_i || pend_nz);

`ifdef OUTPUT_DRIVER_QUEUE_EN
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [PEND_W-1:0] pend_q;
  logic [PEND_W-1:0] pend_d;

  assign pend_nz = (pend_q != '0);

  // When a pulse is started from the queue and a new event arrives in the
  // same cycle, the new event takes the consumed slot: count unchanged and
  // nothing is dropped, even with the queue full.
  always_comb begin
    pend_d = pend_q;
    ovf_d  = ovf_q;
    if (event_i && queue_win) begin
      if (pend_q == PEND_MAX) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pend_q + 1'b1;
      end
    end else if (start && pend_nz && !event_i) begin
      pend_d = pend_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign busy_o = (state_q != IDLE) || pend_nz;
`else
  assign pend_nz = 1'b0;

  always_comb begin
    ovf_d = ovf_q | (event_i & queue_win);
  end

  assign busy_o = (state_q != IDLE);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      if (start) begin
        state_q <= HIGH;
        cnt_q   <= PULSE_LOAD;
        out_q   <= 1'b1;
      end else begin
        case (state_q)
          HIGH: begin
            if (cnt_zero) begin
              state_q <= GAP;
              cnt_q   <= GAP_LOAD;
              out_q   <= 1'b0;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          GAP: begin
            if (cnt_zero) begin
              state_q <= IDLE;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          default: begin
            state_q <= IDLE;
            out_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign pulse_o    = out_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/output_driver.sv
// -----------------------------------------------------------------------------
// output_driver
// Three-channel registered output pulse driver.  Each event strobe becomes a
// PULSE_LEN-cycle output pulse followed by at least GAP_LEN low cycles.
// Ports:
//   clk   : single clock, posedge
//   reset : synchronous active-high reset
//   drv   : output_driver_if.slave (event_1..3 in; output_1..3, busy,
//           overflow out)
// Build option: OUTPUT_DRIVER_QUEUE_EN enables per-channel pending counters
// (depth 2^PEND_W-1) that replay events arriving while a channel is busy.
// -----------------------------------------------------------------------------
module output_driver
  import output_driver_pkg::*;
#(
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN   = 2,
  parameter int PEND_W    = 3
) (
  input logic            clk,
  input logic            reset,
  output_driver_if.slave drv
);

  logic [NUM_CH-1:0] ev_vec;
  logic [NUM_CH-1:0] out_vec;
  logic [NUM_CH-1:0] busy_vec;
  logic [NUM_CH-1:0] ovf_vec;

  assign ev_vec = {drv.event_3, drv.event_2, drv.event_1};

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
      output_driver_chan #(
        .PULSE_LEN (PULSE_LEN),
        .GAP_LEN   (GAP_LEN),
        .PEND_W    (PEND_W)
      ) u_chan (
        .clk        (clk),
        .reset      (reset),
        .event_i    (ev_vec[gi]),
        .pulse_o    (out_vec[gi]),
        .busy_o     (busy_vec[gi]),
        .overflow_o (ovf_vec[gi])
      );
    end
  endgenerate

  assign drv.output_1 = out_vec[0];
  assign drv.output_2 = out_vec[1];
  assign drv.output_3 = out_vec[2];
  assign drv.busy     = busy_vec;
  assign drv.overflow = ovf_vec;

endmodule
